// File: rtl/reset_value_bank_pkg.sv
// Shared types and helpers for the reset-value register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package reset_value_bank_pkg;

   // Sequencer states for the soft-reset window
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_DONE = 2'd2
   } rvb_state_e;

   // LSB position of channel ch inside a packed multi-channel vector
   function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
      return ch * width;
   endfunction

endpackage

// File: rtl/reset_value_bank_if.sv
// Bus bundle between the control/scan side (master) and the register bank (slave).
// Latency: n/a (wires only).
// Backpressure: none; requests arriving outside IDLE are dropped by the bank.
interface reset_value_bank_if #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8
);
   logic [NUM_CH-1:0]       en_i;
   logic [NUM_CH*WIDTH-1:0] data_i;
   logic [NUM_CH*WIDTH-1:0] data_o;
   logic                    soft_rst_req_i;
   logic                    snap_req_i;
   logic                    shift_en_i;
   logic                    shift_i;
   logic                    shift_o;
   logic                    busy_o;
   logic                    done_o;

   modport master (
      output en_i, data_i, soft_rst_req_i, snap_req_i, shift_en_i, shift_i,
      input  data_o, shift_o, busy_o, done_o
   );

   modport slave (
      input  en_i, data_i, soft_rst_req_i, snap_req_i, shift_en_i, shift_i,
      output data_o, shift_o, busy_o, done_o
   );
endinterface

// File: rtl/reset_value_shadow.sv
// Shadow reset-value register: parameter load on reset, parallel snapshot, serial shift.
// Latency: 1 cycle for snapshot/shift; shift_o is bit 0 of the register (pre-edge value visible).
// Backpressure: none; the caller gates snap_i/shift_en_i and snapshot beats shift.
module reset_value_shadow #(
   parameter int                N_BITS       = 32,
   parameter logic [N_BITS-1:0] RESET_VALUES = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              snap_i,
   input  logic [N_BITS-1:0] snap_dat_i,
   input  logic              shift_en_i,
   input  logic              shift_i,
   output logic              shift_o,
   output logic [N_BITS-1:0] shadow_o
);

   logic [N_BITS-1:0] shadow_q;

   // Reset to the parameter image, else snapshot, else shift in at the MSB
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q <= RESET_VALUES;
      end else if (snap_i) begin
         shadow_q <= snap_dat_i;
      end else if (shift_en_i) begin
         shadow_q <= {shift_i, shadow_q[N_BITS-1:1]};
      end
   end

   assign shift_o  = shadow_q[0];
   assign shadow_o = shadow_q;

endmodule

// File: rtl/reset_value_bank.sv
// Multi-channel register bank whose reset values come from a programmable shadow register.
// Latency: 1 cycle capture; soft reset holds shadow values for HOLD_CYCLES then pulses done_o.
// Backpressure: none; requests are taken only in IDLE, others are dropped (busy_o flags HOLD).
module reset_value_bank
   import reset_value_bank_pkg::*;
#(
   parameter int                       NUM_CH       = 4,
   parameter int                       WIDTH        = 8,
   parameter logic [NUM_CH*WIDTH-1:0]  RESET_VALUES = {NUM_CH*WIDTH{1'b0}},
   parameter logic [NUM_CH-1:0]        CH_HAS_RST   = {NUM_CH{1'b1}},
   parameter logic [NUM_CH-1:0]        CH_HAS_EN    = {NUM_CH{1'b1}},
   parameter int                       HOLD_CYCLES  = 2
) (
   input logic               clk_i,
   input logic               rst_i,
   reset_value_bank_if.slave bus
);

   localparam int N_BITS = NUM_CH * WIDTH;
   localparam int CNT_W  = $clog2(HOLD_CYCLES + 1);

   localparam logic [1:0]       S_IDLE   = ST_IDLE;
   localparam logic [1:0]       S_HOLD   = ST_HOLD;
   localparam logic [1:0]       S_DONE   = ST_DONE;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   logic [1:0]        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [N_BITS-1:0] shadow;
   logic [N_BITS-1:0] data_q;
   logic [WIDTH-1:0]  ch_q [NUM_CH];

   logic in_idle;
   logic acc_soft;
   logic acc_snap;
   logic acc_shift;
   logic apply_shadow;

   // Request arbitration: only in IDLE, soft reset > snapshot > shift
   assign in_idle      = (state_q == S_IDLE);
   assign acc_soft     = in_idle & bus.soft_rst_req_i;
   assign acc_snap     = in_idle & ~bus.soft_rst_req_i & bus.snap_req_i;
   assign acc_shift    = in_idle & ~bus.soft_rst_req_i & ~bus.snap_req_i & bus.shift_en_i;
   // Shadow is driven into reset channels on the accepting edge and every HOLD edge
   assign apply_shadow = acc_soft | (state_q == S_HOLD);

   // Soft-reset sequencer: IDLE -> HOLD (HOLD_CYCLES cycles) -> DONE (1 cycle) -> IDLE
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (acc_soft) begin
                  state_q <= S_HOLD;
                  cnt_q   <= '0;
               end
            end
            S_HOLD: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic cap;
      // Channels without an enable capture every cycle
      assign cap = bus.en_i[c] | ~CH_HAS_EN[c];

      if (CH_HAS_RST[c]) begin : g_rst
         // Hard reset to parameter value, soft reset to shadow, else normal capture
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               ch_q[c] <= RESET_VALUES[ch_lsb(c, WIDTH) +: WIDTH];
            end else if (apply_shadow) begin
               ch_q[c] <= shadow[ch_lsb(c, WIDTH) +: WIDTH];
            end else if (cap) begin
               ch_q[c] <= bus.data_i[ch_lsb(c, WIDTH) +: WIDTH];
            end
         end
      end else begin : g_norst
         // Non-reset channel: ignores both reset kinds and just captures
         always_ff @(posedge clk_i) begin
            if (cap) begin
               ch_q[c] <= bus.data_i[ch_lsb(c, WIDTH) +: WIDTH];
            end
         end
      end

      assign data_q[ch_lsb(c, WIDTH) +: WIDTH] = ch_q[c];
   end

   reset_value_shadow #(
      .N_BITS       (N_BITS),
      .RESET_VALUES (RESET_VALUES)
   ) u_shadow (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .snap_i     (acc_snap),
      .snap_dat_i (data_q),
      .shift_en_i (acc_shift),
      .shift_i    (bus.shift_i),
      .shift_o    (bus.shift_o),
      .shadow_o   (shadow)
   );

   assign bus.data_o = data_q;
   assign bus.busy_o = (state_q == S_HOLD);
   assign bus.done_o = (state_q == S_DONE);

endmodule
